// File: rtl/seq_pattern_fsm_if.sv
// Bus bundle for seq_pattern_fsm: stream/config inputs and match/status outputs.
// With SEQ_PATTERN_MASK_EN defined the bundle also carries pattern_mask.
interface seq_pattern_fsm_if #(
   parameter int WIDTH       = 4,
   parameter int COUNT_WIDTH = 8
);
   logic                   enable;
   logic                   din;
   logic                   load;
   logic [WIDTH-1:0]       pattern;
   logic                   overlap;
`ifdef SEQ_PATTERN_MASK_EN
   logic [WIDTH-1:0]       pattern_mask;
`endif
   logic                   match;
   logic [COUNT_WIDTH-1:0] match_count;
   logic [1:0]             status;

`ifdef SEQ_PATTERN_MASK_EN
   modport master (output enable, din, load, pattern, overlap, pattern_mask,
                   input  match, match_count, status);
   modport slave  (input  enable, din, load, pattern, overlap, pattern_mask,
                   output match, match_count, status);
`else
   modport master (output enable, din, load, pattern, overlap,
                   input  match, match_count, status);
   modport slave  (input  enable, din, load, pattern, overlap,
                   output match, match_count, status);
`endif
endinterface

// File: rtl/seq_pattern_fsm.sv
// Loadable serial pattern detector with overlap control and saturating hit count.
// Optional don't-care mask on the compare when SEQ_PATTERN_MASK_EN is defined.
//
// state  | meaning
// IDLE   | no pattern loaded, stream ignored
// FILL   | window not yet holding WIDTH fresh bits
// SEARCH | window full, last compare missed
// HIT    | last compare matched (match output high)
module seq_pattern_fsm #(
   parameter int WIDTH       = 4,
   parameter int COUNT_WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   seq_pattern_fsm_if.slave bus
);
   localparam int FW = $clog2(WIDTH + 1);
   localparam logic [FW-1:0]          FILL_FULL = FW'(WIDTH);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      SEARCH = 2'd2,
      HIT    = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       pat_q, win_q, win_d, next_win;
   logic [FW-1:0]          fill_q, fill_d, fill_inc;
   logic [COUNT_WIDTH-1:0] cnt_q;
   logic                   hit;

   assign next_win = {win_q[WIDTH-2:0], bus.din};
   assign fill_inc = fill_q + FW'(1);

`ifdef SEQ_PATTERN_MASK_EN
   logic [WIDTH-1:0] mask_q;
   assign hit = (((next_win ^ pat_q) & mask_q) == '0);
`else
   assign hit = (next_win == pat_q);
`endif

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      fill_d  = fill_q;
      case (state_q)
         IDLE: ;
         FILL: begin
            if (bus.enable) begin
               win_d  = next_win;
               fill_d = fill_inc;
               if (fill_inc == FILL_FULL) state_d = hit ? HIT : SEARCH;
            end
         end
         SEARCH: begin
            if (bus.enable) begin
               win_d   = next_win;
               state_d = hit ? HIT : SEARCH;
            end
         end
         HIT: begin
            if (bus.overlap) begin
               if (bus.enable) begin
                  win_d   = next_win;
                  state_d = hit ? HIT : SEARCH;
               end else begin
                  state_d = SEARCH;
               end
            end else begin
               // non-overlapping: the compare waits until WIDTH fresh bits arrive
               state_d = FILL;
               if (bus.enable) begin
                  win_d  = next_win;
                  fill_d = FW'(1);
               end else begin
                  fill_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pat_q   <= '0;
         win_q   <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
`ifdef SEQ_PATTERN_MASK_EN
         mask_q  <= '1;
`endif
      end else if (bus.load) begin
         state_q <= FILL;
         pat_q   <= bus.pattern;
         win_q   <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
`ifdef SEQ_PATTERN_MASK_EN
         mask_q  <= bus.pattern_mask;
`endif
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         fill_q  <= fill_d;
         // HIT is only ever held through a fresh compare, so every HIT next-state is an entry
         if (state_d == HIT && cnt_q != CNT_MAX) cnt_q <= cnt_q + COUNT_WIDTH'(1);
      end
   end

   assign bus.match       = (state_q == HIT);
   assign bus.status      = state_q;
   assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_seq_pattern_fsm.sv
// Scoreboard bench for seq_pattern_fsm: a COUNT_WIDTH=8 and a COUNT_WIDTH=2 instance
// share the same stimulus; expected state/count are queued per step and checked after each edge.
module tb_seq_pattern_fsm;
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   seq_pattern_fsm_if #(.WIDTH(4), .COUNT_WIDTH(8)) mif ();
   seq_pattern_fsm_if #(.WIDTH(4), .COUNT_WIDTH(2)) sif ();

   seq_pattern_fsm #(.WIDTH(4), .COUNT_WIDTH(8)) dut     (.clock(clock), .reset_n(reset_n), .bus(mif));
   seq_pattern_fsm #(.WIDTH(4), .COUNT_WIDTH(2)) dut_sat (.clock(clock), .reset_n(reset_n), .bus(sif));

   assign sif.enable  = mif.enable;
   assign sif.din     = mif.din;
   assign sif.load    = mif.load;
   assign sif.pattern = mif.pattern;
   assign sif.overlap = mif.overlap;
`ifdef SEQ_PATTERN_MASK_EN
   assign sif.pattern_mask = mif.pattern_mask;
`endif

   typedef struct {
      logic [1:0] st;
      int         cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic step(input logic en, input logic d, input logic ld, input logic [3:0] pat,
                       input logic ov, input logic [1:0] st, input int cnt);
      @(negedge clock);
      mif.enable  = en;
      mif.din     = d;
      mif.load    = ld;
      mif.pattern = pat;
      mif.overlap = ov;
      exp_q.push_back('{st: st, cnt: cnt});
      @(posedge clock);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("status", 32'(mif.status), 32'(e.st));
            chk("match", 32'(mif.match), 32'(e.st == 2'd3));
            chk("count", 32'(mif.match_count), 32'(e.cnt));
            chk("sat_count", 32'(sif.match_count), 32'((e.cnt > 3) ? 3 : e.cnt));
         end
      end
   end

   initial begin
      logic [6:0] s7;
      logic [3:0] s4;
      logic [1:0] st7[7];
      int         c7[7];
      int         wait_cyc;

      reset_n      = 1'b0;
      mif.enable   = 1'b0;
      mif.din      = 1'b0;
      mif.load     = 1'b0;
      mif.pattern  = '0;
      mif.overlap  = 1'b0;
`ifdef SEQ_PATTERN_MASK_EN
      mif.pattern_mask = '1;
`endif
      #12;
      chk("rst_status", 32'(mif.status), 32'd0);
      chk("rst_match", 32'(mif.match), 32'd0);
      chk("rst_count", 32'(mif.match_count), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // no load: stream is ignored in IDLE
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 0);

      // overlapping 1011 on 1,0,1,1,0,1,1
      s7  = 7'b1011011;
      st7 = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3};
      c7  = '{0, 0, 0, 1, 1, 1, 2};
      step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 2'd1, 0);
      for (int i = 0; i < 7; i++) step(1'b1, s7[6-i], 1'b0, 4'h0, 1'b1, st7[i], c7[i]);

      // non-overlapping, same stream; load from HIT wins
      st7 = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1};
      c7  = '{0, 0, 0, 1, 1, 1, 1};
      step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 2'd1, 0);
      for (int i = 0; i < 7; i++) step(1'b1, s7[6-i], 1'b0, 4'h0, 1'b0, st7[i], c7[i]);
      // fill was 3: one more bit completes the window (0110, no hit)
      step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2, 1);

      // gaps with enable low (din=0 in gaps would corrupt the window if sampled)
      s4 = 4'b1011;
      step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 2'd1, 0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, s4[3-i], 1'b0, 4'h0, 1'b1, (i == 3) ? 2'd3 : 2'd1, (i == 3) ? 1 : 0);
         step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, (i == 3) ? 2'd2 : 2'd1, (i == 3) ? 1 : 0);
      end

      // 1111 overlapping, eight 1s: 5 pulses, sat instance stops at 3
      step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 2'd1, 0);
      for (int i = 0; i < 8; i++)
         step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, (i >= 3) ? 2'd3 : 2'd1, (i >= 3) ? i - 2 : 0);
      // load in HIT alongside a would-be hit: load wins, count cleared
      step(1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd1, 0);

      // reach SEARCH, then async reset mid-cycle
      step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 2'd1, 0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, (i == 3) ? 2'd2 : 2'd1, 0);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_status", 32'(mif.status), 32'd0);
      chk("async_count", 32'(mif.match_count), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      // pattern lost: 1011 stream must not match
      for (int i = 0; i < 4; i++) step(1'b1, s4[3-i], 1'b0, 4'h0, 1'b1, 2'd0, 0);

`ifdef SEQ_PATTERN_MASK_EN
      @(negedge clock);
      mif.pattern_mask = 4'b1001;
      s4 = 4'b1101;
      step(1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 2'd1, 0);
      for (int i = 0; i < 4; i++)
         step(1'b1, s4[3-i], 1'b0, 4'h0, 1'b1, (i == 3) ? 2'd3 : 2'd1, (i == 3) ? 1 : 0);
`endif

      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(negedge clock);
         wait_cyc++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
